pxs_timing_source: RTL
======================

PXS_TIMING_SOURCE -- requirements
Module: pxs_timing_source

Interface
REQ-001 Parameter H_VISIBLE, default 640: visible columns.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 Parameter V_VISIBLE, default 480: visible rows.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical front porch, sync and back porch, in lines.
REQ-005 Parameter SYNC_POL, default 0: asserted level of HS and VS (0 = active-low).
REQ-006 px_clk  input  1: pixel clock; all logic on its rising edge.
REQ-007 reset_n  input  1: asynchronous, active-low reset.
REQ-008 en  input  1: timing advance enable; counters hold while low.
REQ-009 rgb_i  input  3: external pixel colour (used only without PXS_TESTPATTERN_EN).
REQ-010 RGBStr_o  output  26: pixel stream, fields HS, VS, Active, XC, YC, RGB at the positions defined in Pxs.vh.
REQ-011 frame_start  output  1: one-cycle pulse accompanying the stream word with XC=0 and YC=0.
REQ-012 frame_cnt  output  8: completed-frame counter.

Function
REQ-013 hcnt (10b) SHALL count 0..HT-1 with HT=H_VISIBLE+H_FP+H_SYNC+H_BP (800), wrapping to 0, on each px_clk edge with en=1.
REQ-014 vcnt (10b) SHALL increment only when hcnt wraps, count 0..VT-1 with VT=V_VISIBLE+V_FP+V_SYNC+V_BP (525), and wrap to 0.
REQ-015 When hcnt=HT-1, vcnt=VT-1 and en=1, both counters SHALL wrap to 0 and frame_cnt SHALL increment modulo 256.
REQ-016 All RGBStr_o fields and frame_start SHALL be registered copies of values decoded from the current hcnt/vcnt (latency 1 cycle).
REQ-017 XC=hcnt and YC=vcnt, including during blanking.
REQ-018 Active=1 iff hcnt<H_VISIBLE and vcnt<V_VISIBLE.
REQ-019 HS=SYNC_POL iff H_VISIBLE+H_FP <= hcnt < H_VISIBLE+H_FP+H_SYNC (656..751), else ~SYNC_POL.
REQ-020 VS=SYNC_POL iff V_VISIBLE+V_FP <= vcnt < V_VISIBLE+V_FP+V_SYNC (490..491), else ~SYNC_POL.
REQ-021 RGB SHALL be 3'b000 whenever Active=0.
REQ-022 frame_start SHALL be 1 exactly on the output word with hcnt=0, vcnt=0 and en=1, and 0 otherwise.
REQ-023 While en=0, counters and frame_cnt SHALL hold; RGBStr_o SHALL keep re-presenting the held position; frame_start SHALL be 0.
REQ-024 en toggling SHALL neither skip nor repeat positions: the sequence of positions while en=1 SHALL be contiguous.

Reset
REQ-025 While reset_n=0: hcnt=vcnt=0, frame_cnt=0, frame_start=0, Active=0, XC=YC=0, RGB=0, HS=VS=~SYNC_POL.
REQ-026 On the first px_clk edge after reset release with en=1, the output SHALL be XC=0, YC=0, Active=1, frame_start=1.
REQ-027 Assertion of reset_n mid-frame SHALL force the REQ-025 values immediately, without waiting for a clock edge.

Configuration
REQ-028 With PXS_TESTPATTERN_EN defined, active RGB SHALL be a colour-bar pattern, RGB = XC[9:7] (column bands 128 px wide), and rgb_i SHALL be ignored.
REQ-029 Without PXS_TESTPATTERN_EN, active RGB SHALL be rgb_i sampled on the same edge as the position it is paired with.

Verification
REQ-030 Release reset with en=1 -> first word: XC=0, YC=0, Active=1, frame_start=1; 800 cycles later: XC=0, YC=1.
REQ-031 Run one full frame -> exactly 420000 cycles between frame_start pulses; frame_cnt goes 0 -> 1; HS low for 96 consecutive cycles at XC 656..751 on every line; VS low exactly on lines 490 and 491.
REQ-032 Hold en=0 for 5 cycles at XC=300, YC=10 -> output stays at XC=300, YC=10 for those cycles; after en returns to 1, the next word is XC=301.
REQ-033 Assert reset_n=0 at XC=700, YC=200 -> outputs immediately show Active=0, HS=VS=1, XC=YC=0; after release, restart at XC=0, YC=0.
REQ-034 PXS_TESTPATTERN_EN defined -> RGB=3'b010 at XC=300; RGB=0 at XC=650 -- and without the macro, rgb_i=3'b101 -> RGB=3'b101 while Active=1, 0 during blanking.
REQ-035 Run 256 frames -> frame_cnt wraps from 255 to 0 at the 256th frame_start.

Source files
------------

// File: rtl/pxs_timing_source.sv
// Raster timing generator: h/v counters, sync/active decode and a registered 26-bit pixel stream.
// Stream layout (MSB..LSB): HS[25] VS[24] Active[23] XC[22:13] YC[12:3] RGB[2:0]. Define PXS_TESTPATTERN_EN for colour bars.
module pxs_timing_source #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic        px_clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [2:0]  rgb_i,
    output logic [25:0] RGBStr_o,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(HT - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST     = 10'(VT - 1);
    localparam logic [9:0] V_ACT_END  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic       SYNC_ON    = (SYNC_POL != 0);

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       h_last;
    logic       v_last;
    logic       active;
    logic       hs;
    logic       vs;
    logic [2:0] pix_rgb;

    always_comb begin
        h_last  = (hcnt == H_LAST);
        v_last  = (vcnt == V_LAST);
        active  = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
        hs      = ((hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
        vs      = ((vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
        pix_rgb = 3'b000;
`ifdef PXS_TESTPATTERN_EN
        if (active) pix_rgb = hcnt[9:7];
`else
        if (active) pix_rgb = rgb_i;
`endif
    end

`ifdef PXS_TESTPATTERN_EN
    logic unused_rgb;
    assign unused_rgb = ^rgb_i;
`endif

    // Position counters; the frame counter bumps on the edge that wraps the last pixel of the last line.
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt      <= '0;
            vcnt      <= '0;
            frame_cnt <= '0;
        end else if (en) begin
            if (h_last) begin
                hcnt <= '0;
                if (v_last) begin
                    vcnt      <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    vcnt <= vcnt + 10'd1;
                end
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    // The stream word only loads when the counters advance, so a stall re-presents the last position
    // and the next enabled edge continues with the following one.
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            RGBStr_o    <= {~SYNC_ON, ~SYNC_ON, 1'b0, 10'd0, 10'd0, 3'd0};
            frame_start <= 1'b0;
        end else begin
            frame_start <= en && (hcnt == '0) && (vcnt == '0);
            if (en) begin
                RGBStr_o <= {hs, vs, active, hcnt, vcnt, pix_rgb};
            end
        end
    end

endmodule
